// File: rtl/apb_gpio_pkg.sv
// Shared definitions for the APB GPIO completer: register offsets, FSM encoding
// and the address decoder used by the top level.
package apb_gpio_pkg;

    localparam logic [31:0] OFF_DATA_OUT = 32'h00;
    localparam logic [31:0] OFF_DIR      = 32'h04;
    localparam logic [31:0] OFF_DATA_IN  = 32'h08;
    localparam logic [31:0] OFF_IRQ_EN   = 32'h0C;
    localparam logic [31:0] OFF_IRQ_STAT = 32'h10;
    localparam logic [31:0] OFF_ID       = 32'h14;

    localparam logic [31:0] DEFAULT_ID = 32'h4750494F;
    localparam int          CNT_W      = 4;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2
    } fsm_state_e;

    typedef enum logic [2:0] {
        REG_DATA_OUT,
        REG_DIR,
        REG_DATA_IN,
        REG_IRQ_EN,
        REG_IRQ_STAT,
        REG_ID,
        REG_NONE
    } reg_sel_e;

    // Exact match only, so misaligned addresses fall through to REG_NONE.
    function automatic reg_sel_e decode(input logic [31:0] addr);
        case (addr)
            OFF_DATA_OUT: return REG_DATA_OUT;
            OFF_DIR:      return REG_DIR;
            OFF_DATA_IN:  return REG_DATA_IN;
            OFF_IRQ_EN:   return REG_IRQ_EN;
            OFF_IRQ_STAT: return REG_IRQ_STAT;
            OFF_ID:       return REG_ID;
            default:      return REG_NONE;
        endcase
    endfunction

endpackage

// File: rtl/apb_gpio_slave_if.sv
// APB3 bus bundle between a requester (master) and a completer (slave).
interface apb_gpio_slave_if #(
    parameter int ADDR_W = 8
);
    logic              PSEL;
    logic              PENABLE;
    logic [ADDR_W-1:0] PADDR;
    logic              PWRITE;
    logic [31:0]       PWDATA;
    logic [31:0]       PRDATA;
    logic              PREADY;
    logic              PSLVERR;

    modport master (
        output PSEL, PENABLE, PADDR, PWRITE, PWDATA,
        input  PRDATA, PREADY, PSLVERR
    );

    modport slave (
        input  PSEL, PENABLE, PADDR, PWRITE, PWDATA,
        output PRDATA, PREADY, PSLVERR
    );
endinterface

// File: rtl/gpio_sync_edge.sv
// Two-flop synchronizer for asynchronous pins plus a one-cycle rising-edge pulse
// derived from the synchronized value.
module gpio_sync_edge #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic [WIDTH-1:0] rise
);
    logic [WIDTH-1:0] meta_q, sync_q, prev_q;

    // NOTE: sequential state uses non-blocking assignments so every flop samples
    // the pre-edge value of its neighbour; blocking here would collapse the chain.
    always_ff @(posedge clk) begin
        if (rst) begin
            meta_q <= '0;
            sync_q <= '0;
            prev_q <= '0;
        end else begin
            meta_q <= din;
            sync_q <= meta_q;
            prev_q <= sync_q;
        end
    end

    assign dout = sync_q;
    assign rise = sync_q & ~prev_q;
endmodule

// File: rtl/apb_gpio_slave.sv
// APB3 completer exposing a GPIO bank: output data, direction, synchronized
// inputs and rising-edge interrupts, with programmable wait states and PSLVERR.
module apb_gpio_slave
    import apb_gpio_pkg::*;
#(
    parameter int          N_GPIO      = 8,
    parameter int          ADDR_W      = 8,
    parameter int          WAIT_CYCLES = 1,
    parameter logic [31:0] ID_VALUE    = DEFAULT_ID
) (
    input  logic                PCLK,
    input  logic                PRESET,
    apb_gpio_slave_if.slave     bus,
    input  logic [N_GPIO-1:0]   gpio_in,
    output logic [N_GPIO-1:0]   gpio_out,
    output logic [N_GPIO-1:0]   gpio_oe,
    output logic                irq
);
    localparam logic [CNT_W-1:0] WAIT_LOAD = CNT_W'(WAIT_CYCLES);

    fsm_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [N_GPIO-1:0] data_out_q, data_out_d;
    logic [N_GPIO-1:0] dir_q, dir_d;
    logic [N_GPIO-1:0] irq_en_q, irq_en_d;
    logic [N_GPIO-1:0] irq_stat_q, irq_stat_d;
    logic              irq_q, irq_d;

    logic [N_GPIO-1:0] data_in, rise, w1c_mask;
    logic [31:0]       rdata;
    reg_sel_e          sel;
    logic              access, in_xfer, done, violation, addr_err, commit;

    gpio_sync_edge #(.WIDTH(N_GPIO)) u_sync (
        .clk  (PCLK),
        .rst  (PRESET),
        .din  (gpio_in),
        .dout (data_in),
        .rise (rise)
    );

    assign sel       = decode(32'(bus.PADDR));
    assign addr_err  = (sel == REG_NONE) ||
                       (bus.PWRITE && (sel == REG_DATA_IN || sel == REG_ID));
    assign access    = bus.PSEL && bus.PENABLE;
    assign in_xfer   = (state_q == ST_SETUP) || (state_q == ST_ACCESS);
    assign done      = !PRESET && in_xfer && access && (cnt_q == '0);
    assign violation = !PRESET && (state_q == ST_IDLE) && access;
    assign commit    = done && !addr_err;

    // PREADY depends on the live bus so zero-wait and protocol errors answer in-cycle.
    assign bus.PREADY  = done || violation;
    assign bus.PSLVERR = violation || (done && addr_err);
    assign bus.PRDATA  = (commit && !bus.PWRITE) ? rdata : '0;

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path infers a latch.
        rdata = '0;
        case (sel)
            REG_DATA_OUT: rdata = 32'(data_out_q);
            REG_DIR:      rdata = 32'(dir_q);
            REG_DATA_IN:  rdata = 32'(data_in);
            REG_IRQ_EN:   rdata = 32'(irq_en_q);
            REG_IRQ_STAT: rdata = 32'(irq_stat_q);
            REG_ID:       rdata = ID_VALUE;
            default:      rdata = '0;
        endcase
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.PSEL && !bus.PENABLE) begin
                    state_d = ST_SETUP;
                    cnt_d   = WAIT_LOAD;
                end
            end
            ST_SETUP, ST_ACCESS: begin
                if (!bus.PSEL) begin
                    state_d = ST_IDLE;
                end else if (!bus.PENABLE) begin
                    state_d = ST_SETUP;
                    cnt_d   = WAIT_LOAD;
                end else if (cnt_q == '0) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_ACCESS;
                    cnt_d   = cnt_q - 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        data_out_d = data_out_q;
        dir_d      = dir_q;
        irq_en_d   = irq_en_q;
        w1c_mask   = '0;
        if (commit && bus.PWRITE) begin
            case (sel)
                REG_DATA_OUT: data_out_d = bus.PWDATA[N_GPIO-1:0];
                REG_DIR:      dir_d      = bus.PWDATA[N_GPIO-1:0];
                REG_IRQ_EN:   irq_en_d   = bus.PWDATA[N_GPIO-1:0];
                REG_IRQ_STAT: w1c_mask   = bus.PWDATA[N_GPIO-1:0];
                default: ;
            endcase
        end
        // A pin edge in the same cycle as a clear keeps the status bit set.
        irq_stat_d = (irq_stat_q & ~w1c_mask) | rise;
        irq_d      = |(irq_stat_q & irq_en_q);
    end

    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            data_out_q <= '0;
            dir_q      <= '0;
            irq_en_q   <= '0;
            irq_stat_q <= '0;
            irq_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            data_out_q <= data_out_d;
            dir_q      <= dir_d;
            irq_en_q   <= irq_en_d;
            irq_stat_q <= irq_stat_d;
            irq_q      <= irq_d;
        end
    end

    assign gpio_out = data_out_q;
    assign gpio_oe  = dir_q;
    assign irq      = irq_q;

    // Write-data bits above the pin count are intentionally ignored.
    logic unused_pwdata;
    assign unused_pwdata = ^bus.PWDATA;
endmodule
